// File: rtl/ps2_host.sv
// PS/2 host controller: receives device->host frames as bytes and sends host->device
// command bytes using the inhibit / request-to-send handshake.
module ps2_host #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {IDLE, RX, INHIBIT, RTS, TX, TX_ACK, TX_WAIT} state_t;

  // The RTS cycle is counted as part of the clock-low window.
  localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 2);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [3:0]  bit_cnt;
  logic [8:0]  rx_shift;
  logic        rx_stop;
  logic        rx_finish;
  logic [7:0]  tx_byte;
  logic        tx_pending;
  logic [9:0]  tx_shift;
  logic [31:0] cnt;

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
    end
  end

  // Received bytes are judged one cycle after the stop-bit fall, once the FSM is back in IDLE.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= IDLE;
      ps2_clk_out <= 1'b1;
      ps2_dat_out <= 1'b1;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      tx_pending  <= 1'b0;
      tx_byte     <= 8'h00;
      tx_shift    <= '1;
      bit_cnt     <= 4'd0;
      rx_shift    <= 9'd0;
      rx_stop     <= 1'b0;
      rx_finish   <= 1'b0;
      cnt         <= 32'd0;
    end else begin
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      rx_finish <= 1'b0;

      if (rx_finish) begin
        if ((^rx_shift) && rx_stop) begin
          rx_data  <= rx_shift[7:0];
          rx_valid <= 1'b1;
        end else begin
          rx_err <= 1'b1;
        end
      end

      if (tx_req && !tx_busy) begin
        tx_byte    <= tx_data;
        tx_pending <= 1'b1;
        tx_busy    <= 1'b1;
      end

      case (state)
        IDLE: begin
          cnt     <= 32'd0;
          bit_cnt <= 4'd0;
          if (fall && !dat_s2) begin
            state <= RX;
          end else if (tx_pending) begin
            state       <= INHIBIT;
            ps2_clk_out <= 1'b0;
            tx_pending  <= 1'b0;
          end
        end

        RX: begin
          if (fall) begin
            cnt <= 32'd0;
            if (bit_cnt == 4'd9) begin
              rx_stop   <= dat_s2;
              rx_finish <= 1'b1;
              state     <= IDLE;
            end else begin
              rx_shift <= {dat_s2, rx_shift[8:1]};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            rx_err      <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2_dat_out <= 1'b0;
            cnt         <= 32'd0;
            state       <= RTS;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        RTS: begin
          ps2_clk_out <= 1'b1;
          bit_cnt     <= 4'd0;
          cnt         <= 32'd0;
          tx_shift    <= {1'b1, ~^tx_byte, tx_byte};
          state       <= TX;
        end

        TX: begin
          if (fall) begin
            cnt         <= 32'd0;
            ps2_dat_out <= tx_shift[0];
            tx_shift    <= {1'b1, tx_shift[9:1]};
            if (bit_cnt == 4'd9) state <= TX_ACK;
            else bit_cnt <= bit_cnt + 4'd1;
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            tx_err      <= 1'b1;
            tx_busy     <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        TX_ACK: begin
          if (fall) begin
            cnt     <= 32'd0;
            tx_done <= ~dat_s2;
            tx_err  <= dat_s2;
            tx_busy <= 1'b0;
            state   <= TX_WAIT;
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            tx_err      <= 1'b1;
            tx_busy     <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        TX_WAIT: begin
          if (clk_s2 && dat_s2) begin
            state <= IDLE;
          end else if (fall) begin
            cnt <= 32'd0;
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            tx_err      <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host.sv
// Bench for ps2_host: a PS/2 device model on a wired-AND bus drives RX frames and
// answers host transmissions; checks are table vectors plus directed corner sequences.
module tb_ps2_host;

  localparam int INH  = 5000;
  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_out, ps2_dat_out;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       tx_busy, tx_done, tx_err;

  assign ps2_clk_in = dev_clk & ps2_clk_out;
  assign ps2_dat_in = dev_dat & ps2_dat_out;

  ps2_host #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_data(tx_data), .tx_req(tx_req), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk_sys = ~clk_sys;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int fall_cyc = 0;

  int n_valid = 0, n_err = 0, n_done = 0, n_nack = 0;
  int valid_cyc = 0, err_cyc = 0, low_start_cyc = 0, low_cycles = 0;
  int n_overlap = 0, n_long = 0;
  logic done_busy = 1'b1;
  logic prev_clk_out = 1'b1;
  logic [3:0] prev_strobes = 4'd0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Strobe bookkeeping sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk_sys) begin
    if (rx_valid) begin n_valid <= n_valid + 1; valid_cyc <= cyc; end
    if (rx_err)   begin n_err <= n_err + 1; err_cyc <= cyc; end
    if (tx_done)  begin n_done <= n_done + 1; done_busy <= tx_busy; end
    if (tx_err)   n_nack <= n_nack + 1;
    if (rx_valid && rx_err) n_overlap <= n_overlap + 1;
    if ((prev_strobes & {tx_err, tx_done, rx_err, rx_valid}) != 4'd0) n_long <= n_long + 1;
    prev_strobes <= {tx_err, tx_done, rx_err, rx_valid};
    if (!ps2_clk_out) low_cycles <= low_cycles + 1;
    if (!ps2_clk_out && prev_clk_out) low_start_cyc <= cyc;
    prev_clk_out <= ps2_clk_out;
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic dev_bit(input logic b);
    @(negedge clk_sys) dev_dat = b;
    repeat (HALF) @(negedge clk_sys);
    dev_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk_sys);
    dev_clk = 1'b1;
  endtask

  // Device->host frame; req_bit >= 0 pulses tx_req just before that bit.
  task automatic apply_stimulus(input logic [7:0] data, input logic par_flip,
                                input logic stop_val, input int req_bit);
    logic [10:0] frame;
    frame = {stop_val, (~^data) ^ par_flip, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == req_bit) begin
        @(negedge clk_sys) tx_req = 1'b1;
        @(negedge clk_sys) tx_req = 1'b0;
      end
      dev_bit(frame[i]);
    end
    @(negedge clk_sys) dev_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
  endtask

  // Device side of a host->device transfer: wait for inhibit and release, then clock nclk bits.
  task automatic dev_receive(input logic ack, input int nclk,
                             output logic [9:0] bits, output logic start_ok);
    int t;
    bits = '0;
    t = 0;
    while (ps2_clk_out !== 1'b0 && t < 100) begin @(negedge clk_sys); t++; end
    check_output("wait_inhibit_start", int'(t < 100), 1);
    t = 0;
    while (ps2_clk_out !== 1'b1 && t < INH + 100) begin @(negedge clk_sys); t++; end
    check_output("wait_inhibit_end", int'(t < INH + 100), 1);
    repeat (2) @(negedge clk_sys);
    start_ok = (ps2_dat_out == 1'b0);
    for (int i = 0; i < 11 && i < nclk; i++) begin
      repeat (HALF) @(negedge clk_sys);
      if (i == 10 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk_sys);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2_dat_in;
    end
    @(negedge clk_sys) dev_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nv, ne, nd, nn, lc, t;
    logic [9:0] bits;
    logic start_ok;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};

    repeat (5) @(negedge clk_sys);
    check_output("reset_clk_out", int'(ps2_clk_out), 1);
    check_output("reset_dat_out", int'(ps2_dat_out), 1);
    check_output("reset_rx_data", int'(rx_data), 0);
    check_output("reset_strobes", int'({rx_valid, rx_err, tx_done, tx_err}), 0);
    check_output("reset_tx_busy", int'(tx_busy), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);

    dev_dat = 1'b1;
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    dev_clk = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
    check_output("glitch_no_strobe", n_valid + n_err, 0);

    for (int i = 0; i < 7; i++) begin
      nv = n_valid; ne = n_err;
      apply_stimulus(vecs[i].data, vecs[i].par_flip, vecs[i].stop, -1);
      repeat (10) @(negedge clk_sys);
      check_output($sformatf("vec%0d_valid", i), n_valid - nv, int'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_err", i), n_err - ne, int'(vecs[i].exp_err));
      check_output($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_rx));
      if (vecs[i].exp_valid) check_output($sformatf("vec%0d_latency", i), valid_cyc - fall_cyc, 4);
    end

    // Host send of 0xED with device ACK
    nd = n_done; nn = n_nack; lc = low_cycles;
    tx_data = 8'hED;
    @(negedge clk_sys) tx_req = 1'b1;
    @(negedge clk_sys) tx_req = 1'b0;
    check_output("tx_busy_after_req", int'(tx_busy), 1);
    dev_receive(1'b1, 11, bits, start_ok);
    repeat (10) @(negedge clk_sys);
    check_output("tx_inhibit_len", low_cycles - lc, INH);
    check_output("tx_start_bit", int'(start_ok), 1);
    check_output("tx_bits_ED", int'(bits), 32'h3ED);
    check_output("tx_done_count", n_done - nd, 1);
    check_output("tx_err_count", n_nack - nn, 0);
    check_output("tx_busy_at_done", int'(done_busy), 0);
    check_output("tx_busy_end", int'(tx_busy), 0);

    // Host send of 0x00 without ACK
    nd = n_done; nn = n_nack;
    tx_data = 8'h00;
    @(negedge clk_sys) tx_req = 1'b1;
    @(negedge clk_sys) tx_req = 1'b0;
    dev_receive(1'b0, 11, bits, start_ok);
    repeat (10) @(negedge clk_sys);
    check_output("nack_bits_00", int'(bits), 32'h300);
    check_output("nack_err_count", n_nack - nn, 1);
    check_output("nack_done_count", n_done - nd, 0);

    // tx_req arriving in the middle of an RX frame
    nv = n_valid; nd = n_done;
    tx_data = 8'hF4;
    apply_stimulus(8'h3C, 1'b0, 1'b1, 4);
    check_output("midrx_valid", n_valid - nv, 1);
    check_output("midrx_rx_data", int'(rx_data), 32'h3C);
    check_output("midrx_inhibit_after_rx", int'(low_start_cyc >= valid_cyc), 1);
    dev_receive(1'b1, 11, bits, start_ok);
    repeat (10) @(negedge clk_sys);
    check_output("midrx_tx_bits_F4", int'(bits), 32'h2F4);
    check_output("midrx_tx_done", n_done - nd, 1);

    // Device stops clocking after 4 bits
    ne = n_err; nv = n_valid;
    dev_bit(1'b0); dev_bit(1'b0); dev_bit(1'b1); dev_bit(1'b0);
    t = 0;
    while (n_err == ne && t < 2 * TMO) begin @(negedge clk_sys); t++; end
    check_output("timeout_err_count", n_err - ne, 1);
    check_output("timeout_delay_ok", int'((err_cyc - fall_cyc >= TMO) && (err_cyc - fall_cyc <= TMO + 6)), 1);
    check_output("timeout_no_valid", n_valid - nv, 0);
    apply_stimulus(8'hC3, 1'b0, 1'b1, -1);
    repeat (10) @(negedge clk_sys);
    check_output("after_timeout_valid", n_valid - nv, 1);
    check_output("after_timeout_rx_data", int'(rx_data), 32'hC3);

    // Reset in the middle of a transmission
    nd = n_done; nn = n_nack; nv = n_valid;
    tx_data = 8'hF4;
    @(negedge clk_sys) tx_req = 1'b1;
    @(negedge clk_sys) tx_req = 1'b0;
    dev_receive(1'b0, 2, bits, start_ok);
    check_output("midtx_busy_before_reset", int'(tx_busy), 1);
    check_output("midtx_dat_low_before_reset", int'(ps2_dat_out), 0);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_output("midtx_reset_clk_out", int'(ps2_clk_out), 1);
    check_output("midtx_reset_dat_out", int'(ps2_dat_out), 1);
    check_output("midtx_reset_busy", int'(tx_busy), 0);
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (50) @(negedge clk_sys);
    check_output("midtx_no_tx_strobe", (n_done - nd) + (n_nack - nn), 0);
    apply_stimulus(8'h66, 1'b0, 1'b1, -1);
    repeat (10) @(negedge clk_sys);
    check_output("after_reset_valid", n_valid - nv, 1);
    check_output("after_reset_rx_data", int'(rx_data), 32'h66);

    check_output("strobe_overlap", n_overlap, 0);
    check_output("strobe_width", n_long, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
